// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the single-byte I2C master write engine.
//   state_t     - bus sequencer states (also exported on the debug port)
//   PH_*        - quarter-bit phase encodings used inside a 4-tick bit cell
//   RW_WRITE    - R/W bit value appended to the 7-bit slave address
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK1  = 3'd3,
    DATA  = 3'd4,
    ACK2  = 3'd5,
    STOP  = 3'd6,
    DONE  = 3'd7
  } state_t;

  // Quarter-bit phases of a bit cell.
  localparam logic [1:0] PH_SETUP  = 2'd0;  // SCL low, SDA may change
  localparam logic [1:0] PH_RISE   = 2'd1;  // SCL released
  localparam logic [1:0] PH_SAMPLE = 2'd2;  // SCL high, line stable
  localparam logic [1:0] PH_FALL   = 2'd3;  // SCL pulled low

  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_master_write_if.sv
// i2c_master_write_if: request and open-drain bus signals of the write engine.
//   start, addr, data  - transaction request (controller -> engine)
//   sda_in             - sampled SDA line level (pad -> engine)
//   scl, sda_oe        - open-drain bus drive (engine -> pad); 1 on sda_oe pulls low
//   busy, done, ack_err- status (engine -> controller)
//
// Request handshake: the controller pulses start for one clk cycle. The
// engine accepts it only while idle (busy=0); acceptance is visible as busy
// rising on the following cycle. A start seen while busy=1 is dropped. The
// transaction ends with a single-cycle done pulse, coincident with busy
// falling; ack_err is valid from that pulse until the next accepted start.
interface i2c_master_write_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic              sda_in;
  logic              scl;
  logic              sda_oe;
  logic              busy;
  logic              done;
  logic              ack_err;

  modport master (
    input  start, addr, data, sda_in,
    output scl, sda_oe, busy, done, ack_err
  );

  modport slave (
    output start, addr, data, sda_in,
    input  scl, sda_oe, busy, done, ack_err
  );
endinterface

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: edge detector on the divided reference clock.
//   clk       - system clock
//   rst       - synchronous active-high reset
//   scl_ref_i - divided clock from the clock divider, synchronous to clk
//   tick_o    - one-cycle pulse per selected scl_ref edge
// TICK_BOTH_EDGES=1 ticks on every edge, 0 ticks on rising edges only.
module i2c_tick_gen #(
  parameter bit TICK_BOTH_EDGES = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_ref_i,
  output logic tick_o
);

  logic scl_ref_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ref_q <= 1'b0;
    end else begin
      scl_ref_q <= scl_ref_i;
    end
  end

  generate
    if (TICK_BOTH_EDGES) begin : g_both
      assign tick_o = scl_ref_i ^ scl_ref_q;
    end else begin : g_rise
      assign tick_o = scl_ref_i & ~scl_ref_q;
    end
  endgenerate

endmodule

// File: rtl/i2c_master_write.sv
// i2c_master_write: single-byte I2C master write engine.
// Sequence: START, 7-bit address + W, ACK, one data byte, ACK, STOP.
// Every tick (edge of scl_ref) advances the sequencer one quarter-bit.
//   clk         - system clock, all logic on posedge
//   rst         - synchronous active-high reset; aborts and releases the bus
//   scl_ref     - divided clock from the clock divider
//   bus         - request/status/open-drain signals (master modport)
//   dbg_state_o - current sequencer state
module i2c_master_write
  import i2c_pkg::*;
#(
  parameter int ADDR_W          = 7,
  parameter bit TICK_BOTH_EDGES = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl_ref,
  i2c_master_write_if.master       bus,
  output state_t                   dbg_state_o
);

  logic tick;

  i2c_tick_gen #(
    .TICK_BOTH_EDGES(TICK_BOTH_EDGES)
  ) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .scl_ref_i(scl_ref),
    .tick_o   (tick)
  );

  state_t        state_q;
  logic [1:0]    phase_q;
  logic [2:0]    bit_cnt_q;
  logic [ADDR_W:0] shift_q;   // byte on the wire, MSB first
  logic [7:0]    data_q;
  logic          scl_q;
  logic          sda_oe_q;
  logic          busy_q;
  logic          done_q;
  logic          ack_err_q;

  assign bus.scl     = scl_q;
  assign bus.sda_oe  = sda_oe_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= PH_SETUP;
      bit_cnt_q <= 3'd7;
      shift_q   <= '0;
      data_q    <= '0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // Acceptance does not wait for a tick.
        IDLE: begin
          if (bus.start) begin
            shift_q   <= {bus.addr, RW_WRITE};
            data_q    <= bus.data;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b1;
            phase_q   <= PH_SETUP;
            bit_cnt_q <= 3'd7;
            state_q   <= START;
          end
        end

        // Two ticks: SDA falls with SCL high, then SCL falls.
        START: begin
          if (tick) begin
            if (phase_q == PH_SETUP) begin
              sda_oe_q <= 1'b1;
              phase_q  <= PH_RISE;
            end else begin
              scl_q     <= 1'b0;
              phase_q   <= PH_SETUP;
              bit_cnt_q <= 3'd7;
              state_q   <= ADDR;
            end
          end
        end

        // SDA only changes in PH_SETUP, where SCL is low.
        ADDR, DATA: begin
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              PH_SETUP: sda_oe_q <= ~shift_q[bit_cnt_q];
              PH_RISE:  scl_q    <= 1'b1;
              PH_FALL: begin
                scl_q <= 1'b0;
                if (bit_cnt_q == 3'd0) begin
                  bit_cnt_q <= 3'd7;
                  state_q   <= (state_q == ADDR) ? ACK1 : ACK2;
                end else begin
                  bit_cnt_q <= bit_cnt_q - 3'd1;
                end
              end
              default: ;
            endcase
          end
        end

        // ack_err is clear on entry to ACK1, and can only be clear on entry
        // to ACK2, so it doubles as the sampled NACK flag for this slot.
        ACK1, ACK2: begin
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              PH_SETUP:  sda_oe_q <= 1'b0;
              PH_RISE:   scl_q    <= 1'b1;
              PH_SAMPLE: begin
                if (bus.sda_in) begin
                  ack_err_q <= 1'b1;
                end
              end
              PH_FALL: begin
                scl_q <= 1'b0;
                if (state_q == ACK1 && !ack_err_q) begin
                  shift_q <= data_q;
                  state_q <= DATA;
                end else begin
                  state_q <= STOP;
                end
              end
              default: ;
            endcase
          end
        end

        // SDA low, SCL released, then SDA rises while SCL is high.
        STOP: begin
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              PH_SETUP:  sda_oe_q <= 1'b1;
              PH_RISE:   scl_q    <= 1'b1;
              PH_SAMPLE: sda_oe_q <= 1'b0;
              PH_FALL:   state_q  <= DONE;
              default: ;
            endcase
          end
        end

        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          phase_q <= PH_SETUP;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_write.sv
module tb_i2c_master_write;
  import i2c_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_ref = 1'b0;
  state_t dbg_state;

  always #5 clk = ~clk;

  // scl_ref toggles every 13 clk cycles, driven away from the active edge.
  initial begin
    forever begin
      repeat (13) @(negedge clk);
      scl_ref = ~scl_ref;
    end
  end

  i2c_master_write_if bus ();

  // Slave model: wired-AND of master drive and slave ACK pull-down.
  logic slave_pull = 1'b0;
  assign bus.sda_in = ~bus.sda_oe & ~slave_pull;

  i2c_master_write #(
    .ADDR_W(7),
    .TICK_BOTH_EDGES(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_ref    (scl_ref),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [4:0]  rises;   // SCL rising edges incl. STOP rise
    logic [18:0] hist;    // SDA level at each SCL rise, oldest in MSB
    logic        ack_err;
    logic [6:0]  ticks;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int tick_cnt = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  int done_cnt = 0;
  logic [18:0] hist = '0;
  logic ack1_en = 1'b0;
  logic ack2_en = 1'b0;

  initial begin
    logic p_scl, p_sda, p_ref, p_busy, sda;
    exp_t e;
    p_scl = 1'b1; p_sda = 1'b1; p_ref = 1'b0; p_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sda = bus.sda_in;
      if (rst) begin
        tick_cnt = 0; rise_cnt = 0; fall_cnt = 0;
        start_cnt = 0; stop_cnt = 0; hist = '0;
        slave_pull = 1'b0;
      end else begin
        if (scl_ref != p_ref) tick_cnt++;
        if (bus.busy && !p_busy) begin
          tick_cnt = 0; rise_cnt = 0; fall_cnt = 0;
          start_cnt = 0; stop_cnt = 0; hist = '0;
          slave_pull = 1'b0;
        end
        if (p_scl && bus.scl) begin
          if (p_sda && !sda) start_cnt++;
          if (!p_sda && sda) stop_cnt++;
        end
        if (!p_scl && bus.scl) begin
          rise_cnt++;
          hist = {hist[17:0], sda};
        end
        // Fall 1 ends START; falls 9 and 18 end the address/data bytes.
        if (p_scl && !bus.scl) begin
          fall_cnt++;
          slave_pull = (fall_cnt == 9 && ack1_en) || (fall_cnt == 18 && ack2_en);
        end
        if (bus.done) begin
          done_cnt++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=1 expected no done");
          end else begin
            e = exp_q.pop_front();
            check("scl_rises", rise_cnt, int'(e.rises));
            check("sda_bits", int'(hist), int'(e.hist));
            check("ack_err", int'(bus.ack_err), int'(e.ack_err));
            check("busy_at_done", int'(bus.busy), 0);
            check("start_cond", start_cnt, 1);
            check("stop_cond", stop_cnt, 1);
            total++;
            if (tick_cnt < int'(e.ticks) - 1 || tick_cnt > int'(e.ticks) + 1) begin
              bad++;
              $display("FAIL ticks_to_done: got %0d expected %0d", tick_cnt, e.ticks);
            end
          end
        end
      end
      p_scl = bus.scl;
      p_sda = sda;
      p_ref = scl_ref;
      p_busy = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.data  = d;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic issue(input logic [6:0] a, input logic [7:0] d,
                       input logic a1, input logic a2,
                       input logic push, input exp_t e);
    @(negedge clk);
    ack1_en = a1;
    ack2_en = a2;
    if (push) exp_q.push_back(e);
    pulse_start(a, d);
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, done_cnt - d0, 1);
  endtask

  task automatic wait_ticks(input int t);
    int n;
    n = 0;
    while (!(bus.busy && tick_cnt >= t) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("tick_wait_reached", int'(tick_cnt >= t), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;
    rst = 1'b1;

    // Reset held for 3 cycles while scl_ref runs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_scl", int'(bus.scl), 1);
      check("rst_sda_oe", int'(bus.sda_oe), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_ack_err", int'(bus.ack_err), 0);
    end
    check("rst_state", int'(dbg_state), int'(IDLE));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Full write 7'h50 / 8'hA5, both ACKed.
    issue(7'h50, 8'hA5, 1'b1, 1'b1, 1'b1,
          '{rises: 5'd19, hist: 19'b1010_0000_0_1010_0101_0_0, ack_err: 1'b0, ticks: 7'd78});
    wait_done("done_full_write");
    repeat (20) @(negedge clk);

    // Address NACK 7'h3C: data byte skipped.
    issue(7'h3C, 8'h99, 1'b0, 1'b0, 1'b1,
          '{rises: 5'd10, hist: 19'b0111_1000_1_0, ack_err: 1'b1, ticks: 7'd42});
    wait_done("done_addr_nack");
    repeat (20) @(negedge clk);

    // Address ACKed, data 8'hFF NACKed.
    issue(7'h2A, 8'hFF, 1'b1, 1'b0, 1'b1,
          '{rises: 5'd19, hist: 19'b0101_0100_0_1111_1111_1_0, ack_err: 1'b1, ticks: 7'd78});
    wait_done("done_data_nack");
    repeat (20) @(negedge clk);

    // Second start 20 ticks into a transfer is ignored.
    issue(7'h50, 8'h3C, 1'b1, 1'b1, 1'b1,
          '{rises: 5'd19, hist: 19'b1010_0000_0_0011_1100_0_0, ack_err: 1'b0, ticks: 7'd78});
    wait_ticks(20);
    pulse_start(7'h11, 8'h00);
    wait_done("done_start_ignored");
    repeat (200) @(negedge clk);
    check("idle_after_ignored", int'(dbg_state), int'(IDLE));

    // Reset during DATA bit 3 (tick 56 = bit 3, SCL high).
    issue(7'h50, 8'hA5, 1'b1, 1'b1, 1'b0, '0);
    wait_ticks(56);
    check("state_before_abort", int'(dbg_state), int'(DATA));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_scl", int'(bus.scl), 1);
    check("abort_sda_oe", int'(bus.sda_oe), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    // Transaction after abort completes normally.
    issue(7'h50, 8'hA5, 1'b1, 1'b1, 1'b1,
          '{rises: 5'd19, hist: 19'b1010_0000_0_1010_0101_0_0, ack_err: 1'b0, ticks: 7'd78});
    wait_done("done_after_abort");
    repeat (20) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
